// File: rtl/olr_pkg.sv
// Shared definitions for the OLR lane buffer: lane-word field positions,
// write-side packet state and a saturating counter helper.
package olr_pkg;

    localparam int VALID_BIT = 34;
    localparam int LAST_BIT  = 33;
    localparam int HDR_BIT   = 32;
    localparam int DATA_W    = 32;
    localparam int LANE_W    = 35;
    localparam int WORD_W    = LANE_W - 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PKT  = 2'd1,
        W_DISC = 2'd2
    } wr_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && value != 16'hFFFF) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/olr_buf_ram.sv
// DEPTH x WIDTH lane-buffer storage: synchronous write, asynchronous read.
module olr_buf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; readers only see entries covered by
    // committed packets, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/olr_lane_buffer.sv
// Store-and-forward per-lane packet buffer behind the OLR egress stage.
// Optional macro OLR_BUF_STATS_EN adds drop_cnt / proto_err_cnt outputs.
module olr_lane_buffer
    import olr_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANE_W-1:0]          data_in,
    output logic                       buffer_ready,
    output logic                       out_valid,
    output logic [WORD_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
`ifdef OLR_BUF_STATS_EN
    ,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                proto_err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(AFULL_MARGIN);

    wr_state_e         state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, start_q, start_d, wr_addr;
    logic [CW-1:0]     cmt_q, cmt_d, pend_q, pend_w, pend_d, pkt_d, level_d;
    logic              store, rewind, commit, ovf_set, drop_evt, proto_evt;
    logic              pop, pop_last, full;
    logic [WORD_W-1:0] rd_word;

    wire w_valid = data_in[VALID_BIT];
    wire w_last  = data_in[LAST_BIT];
    wire w_hdr   = data_in[HDR_BIT];

    // Level counts committed words plus the packet still being assembled.
    assign level     = cmt_q + pend_q;
    assign full      = (level == DEPTH_C);
    assign out_valid = (pkt_count != '0);
    assign out_data  = out_valid ? rd_word : '0;
    assign pop       = out_valid & out_ready;
    assign pop_last  = pop & rd_word[LAST_BIT];

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        pend_w    = pend_q;
        wr_addr   = wr_ptr_q;
        store     = 1'b0;
        rewind    = 1'b0;
        ovf_set   = 1'b0;
        drop_evt  = 1'b0;
        proto_evt = 1'b0;
        if (w_valid) begin
            unique case (state_q)
                W_IDLE: begin
                    if (!w_hdr) begin
                        proto_evt = 1'b1;
                    end else if (full) begin
                        ovf_set  = 1'b1;
                        drop_evt = 1'b1;
                        if (!w_last) state_d = W_DISC;
                    end else begin
                        store   = 1'b1;
                        start_d = wr_ptr_q;
                        pend_w  = CW'(1);
                    end
                end
                W_PKT: begin
                    if (full) begin
                        rewind   = 1'b1;
                        pend_w   = '0;
                        ovf_set  = 1'b1;
                        drop_evt = 1'b1;
                        state_d  = w_last ? W_IDLE : W_DISC;
                    end else if (w_hdr) begin
                        // Abandon the open packet; the header restarts at its slot.
                        rewind    = 1'b1;
                        proto_evt = 1'b1;
                        drop_evt  = 1'b1;
                        store     = 1'b1;
                        wr_addr   = start_q;
                        pend_w    = CW'(1);
                    end else begin
                        store  = 1'b1;
                        pend_w = pend_q + CW'(1);
                    end
                end
                W_DISC: begin
                    if (w_last) state_d = W_IDLE;
                end
                default: state_d = W_IDLE;
            endcase
        end
        commit = store & w_last;
        if (store) state_d = w_last ? W_IDLE : W_PKT;

        wr_ptr_d = store ? wr_addr + AW'(1) : (rewind ? start_q : wr_ptr_q);
        pend_d   = commit ? '0 : pend_w;
        cmt_d    = cmt_q + (commit ? pend_w : '0) - CW'(pop);
        pkt_d    = pkt_count + CW'(commit) - CW'(pop_last);
        level_d  = cmt_d + pend_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= W_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_q      <= '0;
            cmt_q        <= '0;
            pend_q       <= '0;
            pkt_count    <= '0;
            overflow     <= 1'b0;
            buffer_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            start_q      <= start_d;
            cmt_q        <= cmt_d;
            pend_q       <= pend_d;
            pkt_count    <= pkt_d;
            overflow     <= overflow | ovf_set;
            buffer_ready <= (DEPTH_C - level_d) > MARGIN_C;
        end
    end

`ifdef OLR_BUF_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt      <= '0;
            proto_err_cnt <= '0;
        end else begin
            drop_cnt      <= sat_inc16(drop_cnt, drop_evt);
            proto_err_cnt <= sat_inc16(proto_err_cnt, proto_evt);
        end
    end
`endif

    olr_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (wr_addr),
        .wr_data (data_in[WORD_W-1:0]),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_olr_lane_buffer.sv
// Self-checking bench for olr_lane_buffer: queue-based packet model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_olr_lane_buffer;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [34:0] data_in;
    logic        out_ready;
    logic        buffer_ready, out_valid, overflow;
    logic [33:0] out_data;
    logic [4:0]  pkt_count, level;
`ifdef OLR_BUF_STATS_EN
    logic [15:0] drop_cnt, proto_err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    olr_lane_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .buffer_ready (buffer_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .pkt_count    (pkt_count),
        .level        (level),
        .overflow     (overflow)
`ifdef OLR_BUF_STATS_EN
        ,
        .drop_cnt     (drop_cnt),
        .proto_err_cnt(proto_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: committed words in order, plus the packet being assembled.
    logic [33:0] cq[$];
    logic [33:0] pq[$];
    int          st_m   = 0;   // 0 idle, 1 inside packet, 2 discarding
    bit          ovf_m  = 0;
    bit          br_m   = 0;
    int          drop_m = 0;
    int          prot_m = 0;

    function automatic int npkt_m();
        int n = 0;
        foreach (cq[i]) if (cq[i][33]) n++;
        return n;
    endfunction

    task automatic commit_m();
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
        st_m = 0;
    endtask

    task automatic start_m(input logic [34:0] w);
        pq.push_back(w[33:0]);
        if (w[33]) commit_m();
        else st_m = 1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cq.delete();
            pq.delete();
            st_m  = 0;
            ovf_m = 0;
            br_m  = 0;
            drop_m = 0;
            prot_m = 0;
        end else begin
            automatic bit          full   = (cq.size() + pq.size()) == DEPTH;
            automatic bit          do_pop = (npkt_m() != 0) && out_ready;
            automatic logic [34:0] w      = data_in;
            if (do_pop) void'(cq.pop_front());
            if (w[34]) begin
                if (st_m == 0) begin
                    if (!w[32]) prot_m++;
                    else if (full) begin
                        ovf_m = 1; drop_m++;
                        if (!w[33]) st_m = 2;
                    end else start_m(w);
                end else if (st_m == 1) begin
                    if (full) begin
                        pq.delete(); ovf_m = 1; drop_m++;
                        st_m = w[33] ? 0 : 2;
                    end else if (w[32]) begin
                        prot_m++; drop_m++;
                        pq.delete();
                        start_m(w);
                    end else begin
                        pq.push_back(w[33:0]);
                        if (w[33]) commit_m();
                    end
                end else if (w[33]) begin
                    st_m = 0;
                end
            end
            br_m = (DEPTH - (cq.size() + pq.size())) > MARGIN;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic int np = npkt_m();
        check("out_valid", 64'(out_valid), 64'(np != 0));
        check("pkt_count", 64'(pkt_count), 64'(np));
        check("level", 64'(level), 64'(cq.size() + pq.size()));
        check("overflow", 64'(overflow), 64'(ovf_m));
        check("buffer_ready", 64'(buffer_ready), 64'(br_m));
        if (np != 0) check("out_data", 64'(out_data), 64'(cq[0]));
`ifdef OLR_BUF_STATS_EN
        check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
        check("proto_err_cnt", 64'(proto_err_cnt), 64'(prot_m));
`endif
    end

    function automatic logic [34:0] mk(input bit v, input bit l, input bit h, input logic [31:0] d);
        return {v, l, h, d};
    endfunction

    task automatic cyc(input logic [34:0] w, input bit rdy);
        data_in   = w;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc('0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; data_in = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_buffer_ready", 64'(buffer_ready), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        reset = 1'b1;
        cyc('0, 1'b0);
        check("ready_after_reset", 64'(buffer_ready), 64'd1);

        // Three-word packet held, then popped in order.
        cyc(mk(1, 0, 1, 32'hA), 1'b0);
        cyc(mk(1, 0, 0, 32'hB), 1'b0);
        check("no_valid_before_last", 64'(out_valid), 64'd0);
        cyc(mk(1, 1, 0, 32'hC), 1'b0);
        check("pkt3_valid", 64'(out_valid), 64'd1);
        check("pkt3_count", 64'(pkt_count), 64'd1);
        check("pkt3_level", 64'(level), 64'd3);
        check("pkt3_head", 64'(out_data), 64'h1_0000_000A);
        cyc('0, 1'b1);
        check("pkt3_word1", 64'(out_data), 64'h0_0000_000B);
        cyc('0, 1'b1);
        check("pkt3_word2", 64'(out_data), 64'h2_0000_000C);
        cyc('0, 1'b1);
        check("pkt3_drained", 64'(pkt_count), 64'd0);

        // Fill with single-word packets; the 17th overflows.
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(mk(1, 1, 1, 32'(i)), 1'b0);
            if (i == 13) check("ready_at_13", 64'(buffer_ready), 64'd1);
            if (i == 14) check("ready_at_14", 64'(buffer_ready), 64'd0);
        end
        cyc(mk(1, 1, 1, 32'h99), 1'b0);
        check("full_level", 64'(level), 64'd16);
        check("full_overflow", 64'(overflow), 64'd1);
        drain(DEPTH);

        // Packet overrunning the buffer is rewound and discarded.
        for (int i = 0; i < 14; i++) cyc(mk(1, 1, 1, 32'(i)), 1'b0);
        cyc(mk(1, 0, 1, 32'h40), 1'b0);
        cyc(mk(1, 0, 0, 32'h41), 1'b0);
        cyc(mk(1, 0, 0, 32'h42), 1'b0);
        check("rewind_level", 64'(level), 64'd14);
        cyc(mk(1, 1, 0, 32'h43), 1'b0);
        check("disc_level", 64'(level), 64'd14);
        cyc('0, 1'b1);
        cyc(mk(1, 1, 1, 32'h50), 1'b0);
        check("accept_after_pop", 64'(level), 64'd14);
        drain(14);

        // Header in the middle of a packet restarts it.
        cyc(mk(1, 0, 1, 32'h5), 1'b0);
        cyc(mk(1, 0, 0, 32'h1), 1'b0);
        cyc(mk(1, 0, 1, 32'h7), 1'b0);
        cyc(mk(1, 1, 0, 32'h2), 1'b0);
        check("restart_count", 64'(pkt_count), 64'd1);
        check("restart_head", 64'(out_data), 64'h1_0000_0007);
        drain(2);

        // Commit and last-word pop in the same cycle.
        cyc(mk(1, 1, 1, 32'h11), 1'b0);
        cyc(mk(1, 0, 1, 32'h12), 1'b0);
        cyc(mk(1, 1, 0, 32'h13), 1'b1);
        check("simul_count", 64'(pkt_count), 64'd1);
        check("simul_level", 64'(level), 64'd2);
        drain(2);

        // Asynchronous reset with five words stored, two uncommitted.
        cyc(mk(1, 0, 1, 32'h1), 1'b0);
        cyc(mk(1, 0, 0, 32'h2), 1'b0);
        cyc(mk(1, 1, 0, 32'h3), 1'b0);
        cyc(mk(1, 0, 1, 32'h4), 1'b0);
        cyc(mk(1, 0, 0, 32'h5), 1'b0);
        check("pre_reset_level", 64'(level), 64'd5);
        data_in = '0;
        #1 reset = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_pkt_count", 64'(pkt_count), 64'd0);
        check("async_level", 64'(level), 64'd0);
        check("async_ready", 64'(buffer_ready), 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        cyc('0, 1'b0);
        check("post_reset_ready", 64'(buffer_ready), 64'd1);
        check("post_reset_valid", 64'(out_valid), 64'd0);
        cyc(mk(1, 1, 1, 32'h77), 1'b0);
        check("post_reset_head", 64'(out_data), 64'h3_0000_0077);
        cyc('0, 1'b1);

        // Randomized traffic; reader bias alternates to hit full and empty.
        for (int seg = 0; seg < 16; seg++) begin
            for (int c = 0; c < 200; c++) begin
                automatic bit v = ($urandom % 100) < 70;
                automatic bit h = ($urandom % 100) < 30;
                automatic bit l = ($urandom % 100) < 35;
                automatic bit r = ($urandom % 100) < ((seg % 2) ? 80 : 15);
                cyc(mk(v, l, h, $urandom), r);
            end
        end
        drain(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/olr_lane_buffer.md
Name: olr_lane_buffer

Overview:
- Per-lane packet buffer directly downstream of the OLR egress stage; one instance per lane (data_out0..3 / buffer_ready0..3).
- Accepts 35-bit lane words, stores them in a DEPTH-entry FIFO and drives buffer_ready back as the egress flow-control input.
- Store-and-forward: a packet is presented on the read side only after its last word is written. Incomplete packets are rewound on overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AFULL_MARGIN, 2, buffer_ready deasserts when free entries <= AFULL_MARGIN; this margin absorbs egress words already in flight.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- data_in  input  35  lane word: [34] valid, [33] last, [32] header flag, [31:0] data
- buffer_ready  output  1  space available, registered
- out_valid  output  1  head word is readable
- out_data  output  34  head word [33:0] (last, header, data)
- out_ready  input  1  consumer pop
- pkt_count  output  $clog2(DEPTH+1)  complete packets stored
- level  output  $clog2(DEPTH+1)  occupied entries, including uncommitted words
- overflow  output  1  sticky flag; set on any dropped packet; cleared only by reset

Behaviour:
- Reset (reset=0, async): buffer_ready=0, out_valid=0, out_data=0, pkt_count=0, level=0, overflow=0; pointers=0; write FSM=W_IDLE.
- buffer_ready rises on the first clk edge after reset releases. It is registered as (DEPTH-level_next) > AFULL_MARGIN.
- A write is attempted whenever data_in[34]=1. buffer_ready does not gate writes; it is advisory to the egress stage.
- Write FSM:
  - W_IDLE:
    - Valid word with header=1: store it and latch start_ptr=wr_ptr.
    - If last=1, commit (pkt_count+1) and stay in W_IDLE. Otherwise go to W_PKT.
    - Valid word with header=0: protocol error. Drop the word and stay in W_IDLE.
  - W_PKT:
    - Valid word with header=0: store it. If last=1, commit and go to W_IDLE.
    - Valid word with header=1: protocol error. Rewind wr_ptr to start_ptr, then treat the word as a new packet start (same rules as W_IDLE header).
  - W_DISC: drop all words. A word with last=1 returns the FSM to W_IDLE.
- Full FIFO (level==DEPTH) when a valid word arrives:
  - The word is dropped and overflow is set.
  - In W_PKT: rewind wr_ptr to start_ptr; level drops by the uncommitted count. Go to W_DISC, or to W_IDLE if the dropped word had last=1.
  - In W_IDLE with a header word: drop it. If last=0, go to W_DISC.
- Read side:
  - out_valid = (pkt_count != 0). out_data is the FIFO head, combinational from storage.
  - The reader never sees uncommitted words.
  - Pop on out_valid & out_ready. pkt_count decrements when the popped word has last=1.
- Simultaneous commit and last-word pop: pkt_count is unchanged. A simultaneous write and pop leave level unchanged.
- Rewind and pop in the same cycle: level = committed words minus 1.
- Pointers wrap modulo DEPTH. Full/empty detection uses the level counter.
- Latency: a single-word packet written at edge N gives out_valid=1 after edge N.

Optional Feature:
- Macro: OLR_BUF_STATS_EN.
- Defined:
  - Adds output drop_cnt[15:0], incremented once per dropped or rewound packet.
  - Adds output proto_err_cnt[15:0], incremented once per protocol error.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor the counters exist; overflow remains.

Decomposition:
- olr_pkg holds:
  - word field indices: VALID_BIT=34, LAST_BIT=33, HDR_BIT=32, DATA_W=32;
  - LANE_W=35;
  - write-FSM enum {W_IDLE, W_PKT, W_DISC}.
- Sub-module olr_buf_ram: DEPTH x 34 storage with synchronous write and asynchronous read, parameterised on DEPTH.

Test Plan:
- Reset, then a 3-word packet (hdr 0xA, 0xB, last 0xC) with out_ready=0 -> out_valid rises after the 3rd write; pkt_count=1, level=3. Then out_ready=1 -> 0xA, 0xB, 0xC pop, pkt_count=0.
- Fill with DEPTH single-word packets, no pops -> buffer_ready falls at level 14. A 17th word is dropped, overflow=1, level stays 16.
- With 14 entries committed, send a 4-word packet -> 2 words stored, 3rd word hits full, level rewinds to 14, FSM in W_DISC. 4th word (last) is dropped. Next header is accepted after a pop.
- Header mid-packet: hdr, 0x1, hdr2, last 0x2 -> only the hdr2/0x2 packet is stored, pkt_count=1. With OLR_BUF_STATS_EN, proto_err_cnt=1.
- Simultaneous last-word write and last-word pop with pkt_count=1 -> pkt_count stays 1, level unchanged.
- Assert reset low mid-packet with 5 words stored -> all outputs 0 immediately (async). After release, buffer_ready=1 on the next edge and old data is never presented.
